// File: rtl/systolic_sequencer_if.sv
// rtl/systolic_sequencer_if.sv - sequencer bus: command, serial operand input, core operands, tx handshake
`timescale 1ns/1ps
interface systolic_sequencer_if #(
  parameter int D_W = 8,
  parameter int N   = 2
);
  logic                 start;
  logic                 reuse_b;
  logic                 ser_in;
  logic                 ser_valid;
  logic                 tx_ready;
  logic [N*N*D_W-1:0]   core_in_a;
  logic [N*N*D_W-1:0]   core_in_b;
  logic                 core_clr;
  logic                 core_en;
  logic                 init;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, reuse_b, ser_in, ser_valid, tx_ready,
    output core_in_a, core_in_b, core_clr, core_en, init, busy, done
  );

  modport slave (
    output start, reuse_b, ser_in, ser_valid, tx_ready,
    input  core_in_a, core_in_b, core_clr, core_en, init, busy, done
  );
endinterface

// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - TPU sequencer: serial operand load, clear, compute window, tx handshake
// Optional B-matrix reuse is enabled by defining SEQ_WEIGHT_REUSE_EN.
`timescale 1ns/1ps
module systolic_sequencer #(
  parameter int D_W            = 8,
  parameter int N              = 2,
  parameter int COMPUTE_CYCLES = 3*N-2
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_sequencer_if.master  bus
);
  localparam int W  = N*N*D_W;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = $clog2(COMPUTE_CYCLES+1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W-1);
  localparam logic [CW-1:0] COMP_LAST = CW'(COMPUTE_CYCLES-1);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, CLEAR, COMPUTE, START_TX, WAIT_TX_HI, WAIT_TX_LO, DONE
  } state_t;

  state_t          state, state_n;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   comp_cnt;
  logic [W-1:0]    a_q, b_q;
  logic            reuse_q;
  logic            reuse_sel;
  logic            clr_c, en_c, init_c, busy_c, done_c;

`ifdef SEQ_WEIGHT_REUSE_EN
  assign reuse_sel = bus.reuse_b;
`else
  // reuse_b has no effect in this build
  assign reuse_sel = bus.reuse_b & 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    clr_c   = 1'b0;
    en_c    = 1'b0;
    init_c  = 1'b0;
    busy_c  = 1'b1;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_n = LOAD_A;
      end
      LOAD_A: if (bus.ser_valid && bit_cnt == BIT_LAST) state_n = reuse_q ? CLEAR : LOAD_B;
      LOAD_B: if (bus.ser_valid && bit_cnt == BIT_LAST) state_n = CLEAR;
      CLEAR: begin
        clr_c   = 1'b1;
        state_n = COMPUTE;
      end
      COMPUTE: begin
        en_c = 1'b1;
        if (comp_cnt == COMP_LAST) state_n = START_TX;
      end
      START_TX: begin
        init_c  = 1'b1;
        state_n = WAIT_TX_HI;
      end
      WAIT_TX_HI: if (bus.tx_ready)  state_n = WAIT_TX_LO;
      WAIT_TX_LO: if (!bus.tx_ready) state_n = DONE;
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      comp_cnt <= '0;
      a_q      <= '0;
      b_q      <= '0;
      reuse_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) reuse_q <= reuse_sel;
      // counters restart on every state entry
      if (state_n != state) begin
        bit_cnt  <= '0;
        comp_cnt <= '0;
      end else begin
        if ((state == LOAD_A || state == LOAD_B) && bus.ser_valid) bit_cnt <= bit_cnt + 1'b1;
        if (state == COMPUTE) comp_cnt <= comp_cnt + 1'b1;
      end
      if (bus.ser_valid && state == LOAD_A) a_q[bit_cnt] <= bus.ser_in;
      if (bus.ser_valid && state == LOAD_B) b_q[bit_cnt] <= bus.ser_in;
    end
  end

  assign bus.core_in_a = a_q;
  assign bus.core_in_b = b_q;
  assign bus.core_clr  = clr_c;
  assign bus.core_en   = en_c;
  assign bus.init      = init_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - scoreboard bench for systolic_sequencer
`timescale 1ns/1ps
module tb_systolic_sequencer;
  localparam int D_W = 8;
  localparam int N   = 2;
  localparam int W   = N*N*D_W;
  localparam int CC  = 4;

  localparam logic [W-1:0] A0 = 32'h04030201;
  localparam logic [W-1:0] B0 = 32'h08070605;
  localparam logic [W-1:0] A9 = 32'h09090909;

  logic clk = 1'b0;
  logic rst = 1'b1;

  systolic_sequencer_if #(.D_W(D_W), .N(N)) bus ();
  systolic_sequencer #(.D_W(D_W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           load;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0;
  int done_cnt = 0, pushed = 0, stray = 0;
  int load_cyc = 0, clr_cnt = 0, en_cnt = 0, init_cnt = 0;
  bit seen_clr = 0, chk_idle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      load_cyc = 0; clr_cnt = 0; en_cnt = 0; init_cnt = 0;
      seen_clr = 0; chk_idle = 0;
    end else begin
      if (chk_idle) begin
        check("busy_after_done", bus.busy, 0);
        chk_idle = 0;
      end
      if (!bus.busy && (bus.core_clr | bus.core_en | bus.init | bus.done)) stray++;
      if (bus.busy && !seen_clr && !bus.core_clr) load_cyc++;
      if (bus.core_clr) begin clr_cnt++; seen_clr = 1; end
      if (bus.core_en) en_cnt++;
      if (bus.init) init_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb.pop_front();
          check("core_in_a", bus.core_in_a, e.a);
          check("core_in_b", bus.core_in_b, e.b);
          check("load_cycles", load_cyc, e.load);
          check("clr_cycles", clr_cnt, 1);
          check("en_cycles", en_cnt, CC);
          check("init_cycles", init_cnt, 1);
        end
        load_cyc = 0; clr_cnt = 0; en_cnt = 0; init_cnt = 0;
        seen_clr = 0; chk_idle = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_start(input bit reuse);
    bus.start = 1'b1; bus.reuse_b = reuse;
    tick();
    bus.start = 1'b0; bus.reuse_b = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nbits, input bit gapped);
    for (int i = 0; i < nbits; i++) begin
      bus.ser_valid = 1'b1; bus.ser_in = w[i];
      tick();
      if (gapped) begin
        bus.ser_valid = 1'b0; bus.ser_in = ~w[i];
        tick();
      end
    end
    bus.ser_valid = 1'b0;
  endtask

  // sel: 0 = core_en high, 1 = init high, 2 = busy low
  task automatic wait_out(input int sel, input string name);
    int n = 0;
    bit hit = 0;
    while (n < 400 && !hit) begin
      case (sel)
        0:       hit = bus.core_en;
        1:       hit = bus.init;
        default: hit = !bus.busy;
      endcase
      if (!hit) begin tick(); n++; end
    end
    if (!hit) check(name, 0, 1);
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int load);
    exp_t x;
    x.a = a; x.b = b; x.load = load;
    sb.push_back(x);
    pushed++;
  endtask

  task automatic finish_tx(input int hi);
    wait_out(1, "timeout_init");
    tick(); tick();
    bus.tx_ready = 1'b1;
    repeat (hi) tick();
    bus.tx_ready = 1'b0;
    wait_out(2, "timeout_idle");
  endtask

  task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit gapped, input int load);
    push(a, b, load);
    issue_start(0);
    send_bits(a, W, gapped);
    send_bits(b, W, gapped);
    finish_tx(64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int stall_bad;
    bus.start = 0; bus.reuse_b = 0; bus.ser_in = 0; bus.ser_valid = 0; bus.tx_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // asynchronous reset in the middle of a load
    issue_start(0);
    send_bits(32'h000000FF, 8, 0);
    check("pre_reset_busy", bus.busy, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("reset_ctrl", {bus.busy, bus.done, bus.init, bus.core_en, bus.core_clr}, 0);
    check("reset_a", bus.core_in_a, 0);
    check("reset_b", bus.core_in_b, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) tick();
    check("idle_busy", bus.busy, 0);
    check("idle_stray", stray, 0);
    check("idle_done", done_cnt, 0);

    full_op(A0, B0, 0, 2*W);
    check("hold_a", bus.core_in_a, A0);
    check("hold_b", bus.core_in_b, B0);

    full_op(A0, B0, 1, 4*W-1);

    // start pulses during COMPUTE and WAIT_TX_HI must be ignored
    push(A0, B0, 2*W);
    issue_start(0);
    send_bits(A0, W, 0);
    send_bits(B0, W, 0);
    wait_out(0, "timeout_en");
    issue_start(0);
    wait_out(1, "timeout_init");
    tick(); tick();
    issue_start(0);
    bus.tx_ready = 1'b1;
    repeat (64) tick();
    bus.tx_ready = 1'b0;
    wait_out(2, "timeout_idle");
    repeat (5) tick();
    check("ignored_start_idle", bus.busy, 0);

    // stalled serialiser holds the sequencer in WAIT_TX_HI
    push(A0, B0, 2*W);
    issue_start(0);
    send_bits(A0, W, 0);
    send_bits(B0, W, 0);
    wait_out(1, "timeout_init");
    stall_bad = 0;
    repeat (500) begin
      tick();
      if (!bus.busy || bus.done) stall_bad++;
    end
    check("stall_hold", stall_bad, 0);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    wait_out(2, "timeout_idle");

`ifdef SEQ_WEIGHT_REUSE_EN
    push(A9, B0, W);
    issue_start(1);
    send_bits(A9, W, 0);
    finish_tx(64);
`else
    push(A9, B0, 2*W+10);
    issue_start(1);
    send_bits(A9, W, 0);
    repeat (10) tick();
    check("wait_load_b_busy", bus.busy, 1);
    check("wait_load_b_noclr", clr_cnt, 0);
    send_bits(B0, W, 0);
    finish_tx(64);
`endif

    // reset during LOAD_B aborts without done
    issue_start(0);
    send_bits(A0, W, 0);
    send_bits(B0, 10, 0);
    check("load_b_busy", bus.busy, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("abort_a", bus.core_in_a, 0);
    check("abort_b", bus.core_in_b, 0);
    check("abort_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) tick();

    check("sb_empty", sb.size(), 0);
    check("done_total", done_cnt, pushed);
    check("stray_total", stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
